// File: rtl/delay_line.sv
// Single-channel audio delay line with optional saturating feedback (echo).
// One sample per strobe through a 3-stage pipeline around a synchronous-read circular RAM.
module delay_line #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4096,
    parameter int ADDR_W   = 12,
    parameter int FB_SHIFT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sampleValid_i,
    input  logic signed [WIDTH-1:0]  sample_i,
    input  logic        [ADDR_W-1:0] delaySamples_i,
    input  logic                     fbEn_i,
    output logic signed [WIDTH-1:0]  wet_o,
    output logic                     wetValid_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam logic signed [WIDTH:0] SAT_MAX = (WIDTH+1)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [WIDTH:0] SAT_MIN = -(WIDTH+1)'(2 ** (WIDTH - 1));
    localparam logic [ADDR_W-1:0]     FILL_MAX = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0] ram [DEPTH];

    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        fill;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W-1:0]        dly;
    logic signed [WIDTH-1:0]  smp;
    logic                     fb_en;
    logic [WIDTH-1:0]         ram_q;
    logic                     stage_read;
    logic                     stage_write;
    logic                     stage_out;

    logic                     accept;
    logic [ADDR_W-1:0]        dly_eff;
    logic signed [WIDTH-1:0]  rd_val;
    logic signed [WIDTH-1:0]  rd_scaled;
    logic signed [WIDTH:0]    fb_sum;
    logic signed [WIDTH-1:0]  wr_val;

    assign busy_o     = stage_read | stage_write;
    assign wetValid_o = stage_out;
    assign accept     = sampleValid_i & ~busy_o;
    assign dly_eff    = (delaySamples_i == '0) ? ADDR_W'(1) : delaySamples_i;

    // Fill counter hides stale RAM contents until D samples have been written.
    always_comb begin
        rd_val    = (fill >= dly) ? $signed(ram_q) : '0;
        rd_scaled = rd_val >>> FB_SHIFT;
        fb_sum    = {smp[WIDTH-1], smp} + {rd_scaled[WIDTH-1], rd_scaled};
        wr_val    = smp;
        if (fb_en) begin
            if (fb_sum > SAT_MAX) begin
                wr_val = SAT_MAX[WIDTH-1:0];
            end else if (fb_sum < SAT_MIN) begin
                wr_val = SAT_MIN[WIDTH-1:0];
            end else begin
                wr_val = fb_sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            fill        <= '0;
            rd_addr     <= '0;
            dly         <= ADDR_W'(1);
            smp         <= '0;
            fb_en       <= 1'b0;
            stage_read  <= 1'b0;
            stage_write <= 1'b0;
            stage_out   <= 1'b0;
            wet_o       <= '0;
            overrun_o   <= 1'b0;
        end else begin
            stage_read  <= accept;
            stage_write <= stage_read;
            stage_out   <= stage_write;
            if (accept) begin
                smp     <= sample_i;
                dly     <= dly_eff;
                fb_en   <= fbEn_i;
                rd_addr <= wr_ptr - dly_eff;
            end
            if (stage_write) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                fill   <= (fill == FILL_MAX) ? fill : fill + ADDR_W'(1);
                wet_o  <= rd_val;
            end
            if (sampleValid_i && busy_o) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // NOTE: the sample RAM has no reset so it maps onto block RAM; the fill counter
    // keeps its stale contents from ever reaching wet_o.
    always_ff @(posedge clk_i) begin
        if (stage_read) begin
            ram_q <= ram[rd_addr];
        end
        if (stage_write && !rst_i) begin
            ram[wr_ptr] <= wr_val;
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// Directed scoreboard bench for delay_line (DEPTH=8): stimulus pushes expected wet
// samples with their due cycle; a negedge monitor pops and compares on each wetValid_o.
module tb_delay_line;

    localparam int W   = 16;
    localparam int DEP = 8;
    localparam int AW  = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 sampleValid_i;
    logic signed [W-1:0]  sample_i;
    logic [AW-1:0]        delaySamples_i;
    logic                 fbEn_i;
    logic signed [W-1:0]  wet_o;
    logic                 wetValid_o;
    logic                 busy_o;
    logic                 overrun_o;

    delay_line #(
        .WIDTH(W), .DEPTH(DEP), .ADDR_W(AW), .FB_SHIFT(1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sampleValid_i  (sampleValid_i),
        .sample_i       (sample_i),
        .delaySamples_i (delaySamples_i),
        .fbEn_i         (fbEn_i),
        .wet_o          (wet_o),
        .wetValid_o     (wetValid_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc++;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every wetValid_o pulse must match the oldest expectation, on time.
    always @(negedge clk_i) begin
        if (wetValid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wet_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wet", int'(wet_o), e.val);
                check("wet_latency", cyc, e.due);
                check("busy_at_wet", int'(busy_o), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send(input int s, input int d, input bit fb, input bit expect_out,
                        input int exp_val, input int gap);
        sampleValid_i  = 1'b1;
        sample_i       = W'(s);
        delaySamples_i = AW'(d);
        fbEn_i         = fb;
        if (expect_out) sb.push_back('{exp_val, cyc + 3});
        @(posedge clk_i);
        #1 sampleValid_i = 1'b0;
        if (expect_out) check("busy_after_accept", int'(busy_o), 1);
        repeat (gap - 1) @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        sampleValid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("rst_wet", int'(wet_o), 0);
        check("rst_wet_valid", int'(wetValid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_overrun", int'(overrun_o), 0);
    endtask

    int t2e[6]  = '{0, 0, 0, 1, 2, 3};
    int t3s[7]  = '{1000, 0, 0, 0, 0, 0, 0};
    int t3e[7]  = '{0, 1000, 500, 250, 125, 62, 31};
    int t3ns[6] = '{-1000, 0, 0, 0, 0, 0};
    int t3ne[6] = '{0, -1000, -500, -250, -125, -63};
    int t4s[3]  = '{30000, 30000, 0};
    int t4e[3]  = '{0, 30000, 32767};
    int t4ns[3] = '{-30000, -30000, 0};
    int t4ne[3] = '{0, -30000, -32768};

    initial begin
        rst_i          = 1'b1;
        sampleValid_i  = 1'b0;
        sample_i       = '0;
        delaySamples_i = '0;
        fbEn_i         = 1'b0;
        @(posedge clk_i);
        #1;
        do_reset();

        // Idle after reset: everything stays quiet.
        repeat (20) begin
            @(posedge clk_i);
            #1;
            check("idle_wet", int'(wet_o), 0);
            check("idle_wet_valid", int'(wetValid_o), 0);
            check("idle_busy", int'(busy_o), 0);
            check("idle_overrun", int'(overrun_o), 0);
        end

        // Plain delay of 3, no feedback.
        for (int i = 0; i < 6; i++) send(i + 1, 3, 1'b0, 1'b1, t2e[i], 5);
        drain();

        // Feedback impulse response, positive then negative.
        do_reset();
        for (int i = 0; i < 7; i++) send(t3s[i], 1, 1'b1, 1'b1, t3e[i], 5);
        drain();
        do_reset();
        for (int i = 0; i < 6; i++) send(t3ns[i], 1, 1'b1, 1'b1, t3ne[i], 5);
        drain();

        // Feedback saturation at both rails.
        do_reset();
        for (int i = 0; i < 3; i++) send(t4s[i], 1, 1'b1, 1'b1, t4e[i], 5);
        drain();
        do_reset();
        for (int i = 0; i < 3; i++) send(t4ns[i], 1, 1'b1, 1'b1, t4ne[i], 5);
        drain();

        // Back-to-back strobes: second is dropped, overrun sticks.
        do_reset();
        sampleValid_i  = 1'b1;
        sample_i       = W'(77);
        delaySamples_i = AW'(1);
        fbEn_i         = 1'b0;
        sb.push_back('{0, cyc + 3});
        @(posedge clk_i);
        #1 sample_i = W'(88);
        @(posedge clk_i);
        #1 sampleValid_i = 1'b0;
        check("overrun_set", int'(overrun_o), 1);
        repeat (3) @(posedge clk_i);
        #1;
        send(5, 1, 1'b0, 1'b1, 77, 5);
        send(6, 1, 1'b0, 1'b1, 5, 5);
        drain();
        check("overrun_sticky", int'(overrun_o), 1);

        // Maximum delay across pointer wrap at minimum strobe spacing.
        do_reset();
        for (int k = 1; k <= 20; k++) send(k, 7, 1'b0, 1'b1, (k > 7) ? k - 7 : 0, 3);
        drain();

        // Reset in the cycle after a strobe: no output pulse.
        sampleValid_i  = 1'b1;
        sample_i       = W'(123);
        delaySamples_i = AW'(1);
        fbEn_i         = 1'b0;
        @(posedge clk_i);
        #1 sampleValid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_wet", int'(wet_o), 0);

        // Fill restarted after reset; then zero delay acts as one.
        send(9, 2, 1'b0, 1'b1, 0, 5);
        send(8, 2, 1'b0, 1'b1, 0, 5);
        send(7, 2, 1'b0, 1'b1, 9, 5);
        send(5, 0, 1'b0, 1'b1, 7, 5);
        send(6, 0, 1'b0, 1'b1, 5, 5);
        drain();

        // Reset and strobe together: reset wins.
        rst_i          = 1'b1;
        sampleValid_i  = 1'b1;
        sample_i       = W'(55);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        sampleValid_i = 1'b0;
        check("rst_strobe_busy", int'(busy_o), 0);
        repeat (5) @(posedge clk_i);
        #1;
        check("rst_strobe_overrun", int'(overrun_o), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
